// File: rtl/ball_controller.sv
// ----------------------------------------------------------------------------
// ball_controller
// Pong ball engine. It moves a square ball once per frame and bounces it off
// the top and bottom walls and off the two paddles. A ball that gets past a
// paddle scores a point for the other side. After a point the ball is held for
// a fixed number of frames and then re-centred. Play waits for a serve, and the
// game ends when either side reaches the winning score.
//
// Ports
//   clk                       system clock, all state on posedge
//   rst                       asynchronous active-high reset
//   frame_tick                one-cycle pulse per frame
//   serve                     level; starts a point (SERVE) or a new game (GAME_OVER)
//   lpad_top/lpad_bottom      left paddle vertical bounds
//   rpad_top/rpad_bottom      right paddle vertical bounds
//   top/bottom/left/right_bound  registered ball rectangle, drawn with strict
//                             inequalities (so each edge is one pixel outside)
//   score_left/score_right    points, saturating at WIN_SCORE
//   state                     SERVE=0, PLAY=1, SCORED=2, GAME_OVER=3
//   hit                       one-cycle pulse on a paddle bounce
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SERVE      | ball centred, waiting for serve
// PLAY       | ball moves one step per frame_tick
// SCORED     | point taken, holding SCORE_HOLD frames before re-centring
// GAME_OVER  | a side reached WIN_SCORE, waiting for serve to restart
// ----------------------------------------------------------------------------
module ball_controller #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int SPEED      = 2,
    parameter int LPAD_X     = 20,
    parameter int RPAD_X     = 620,
    parameter int SCORE_HOLD = 60,
    parameter int WIN_SCORE  = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [11:0] lpad_top,
    input  logic [11:0] lpad_bottom,
    input  logic [11:0] rpad_top,
    input  logic [11:0] rpad_bottom,
    output logic [11:0] top_bound,
    output logic [11:0] bottom_bound,
    output logic [11:0] left_bound,
    output logic [11:0] right_bound,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic [1:0]  state,
    output logic        hit
);

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam logic [11:0] X_MAX = 12'(SCREEN_W - BALL_SIZE - 1);
    localparam logic [11:0] Y_MAX = 12'(SCREEN_H - BALL_SIZE - 1);
    localparam logic [11:0] X_C   = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [11:0] Y_C   = 12'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [11:0] SP12  = 12'(SPEED);
    localparam logic [11:0] B1_12 = 12'(BALL_SIZE + 1);
    localparam logic [11:0] LPX   = 12'(LPAD_X);
    localparam logic [11:0] RPX_L = 12'(RPAD_X - BALL_SIZE - 1);

    // 13-bit copies keep the edge compares free of wrap-around.
    localparam logic [12:0] SP13    = 13'(SPEED);
    localparam logic [12:0] B1_13   = 13'(BALL_SIZE + 1);
    localparam logic [12:0] XMAX13  = 13'(SCREEN_W - BALL_SIZE - 1);
    localparam logic [12:0] YMAX13  = 13'(SCREEN_H - BALL_SIZE - 1);
    localparam logic [12:0] LPX13   = 13'(LPAD_X);
    localparam logic [12:0] RPX13   = 13'(RPAD_X);
    localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);

    localparam int CW = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(SCORE_HOLD - 1);

    // Direction encodings: dx 1 = right, dy 1 = down, loser 1 = right side.
    state_t         state_q, state_d;
    logic [11:0]    x_q, x_d, y_q, y_d;
    logic           dx_q, dx_d, dy_q, dy_d;
    logic           loser_q, loser_d;
    logic [3:0]     sl_q, sl_d, sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hit_q, hit_d;
    logic [11:0]    top_q, bot_q, left_q, right_q;

    logic [12:0]    x_w, y_w;
    logic           ov_l, ov_r;
    logic [11:0]    x_mv, y_mv;
    logic           dx_mv, dy_mv, bounce, pt_l, pt_r;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN4) ? s : s + 4'd1;
    endfunction

    assign x_w = {1'b0, x_q};
    assign y_w = {1'b0, y_q};

    // Paddle overlap is judged on the position before this frame's move.
    assign ov_l = (y_q < lpad_bottom) && ((y_w + B1_13) > {1'b0, lpad_top});
    assign ov_r = (y_q < rpad_bottom) && ((y_w + B1_13) > {1'b0, rpad_top});

    // One frame of motion; horizontal and vertical resolve independently.
    always_comb begin
        x_mv   = x_q;
        y_mv   = y_q;
        dx_mv  = dx_q;
        dy_mv  = dy_q;
        bounce = 1'b0;
        pt_l   = 1'b0;
        pt_r   = 1'b0;

        if (dy_q) begin
            if ((y_w + SP13) >= YMAX13) begin
                y_mv  = Y_MAX;
                dy_mv = 1'b0;
            end else begin
                y_mv = y_q + SP12;
            end
        end else begin
            if (y_w <= SP13) begin
                y_mv  = 12'd0;
                dy_mv = 1'b1;
            end else begin
                y_mv = y_q - SP12;
            end
        end

        // A paddle bounce is tested before the score edge, so it wins.
        if (dx_q) begin
            if (((x_w + B1_13 + SP13) >= RPX13) && ov_r) begin
                x_mv   = RPX_L;
                dx_mv  = 1'b0;
                bounce = 1'b1;
            end else if ((x_w + SP13) >= XMAX13) begin
                x_mv = X_MAX;
                pt_l = 1'b1;
            end else begin
                x_mv = x_q + SP12;
            end
        end else begin
            if ((x_w <= (LPX13 + SP13)) && ov_l) begin
                x_mv   = LPX;
                dx_mv  = 1'b1;
                bounce = 1'b1;
            end else if (x_w <= SP13) begin
                x_mv = 12'd0;
                pt_r = 1'b1;
            end else begin
                x_mv = x_q - SP12;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        loser_d = loser_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;

        case (state_q)
            ST_SERVE: begin
                if (serve) begin
                    state_d = ST_PLAY;
                    dx_d    = loser_q;
                    dy_d    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    x_d   = x_mv;
                    y_d   = y_mv;
                    dx_d  = dx_mv;
                    dy_d  = dy_mv;
                    hit_d = bounce;
                    if (pt_l) begin
                        sl_d    = sat_inc(sl_q);
                        loser_d = 1'b1;
                        state_d = ST_SCORED;
                        cnt_d   = HOLD_LOAD;
                    end else if (pt_r) begin
                        sr_d    = sat_inc(sr_q);
                        loser_d = 1'b0;
                        state_d = ST_SCORED;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            ST_SCORED: begin
                // Down-counter loaded with HOLD-1; the tick seen at zero is the last one.
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        x_d     = X_C;
                        y_d     = Y_C;
                        state_d = ((sl_q == WIN4) || (sr_q == WIN4)) ? ST_OVER : ST_SERVE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (serve) begin
                    sl_d    = 4'd0;
                    sr_d    = 4'd0;
                    x_d     = X_C;
                    y_d     = Y_C;
                    state_d = ST_SERVE;
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SERVE;
            x_q     <= X_C;
            y_q     <= Y_C;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            loser_q <= 1'b1;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            top_q   <= Y_C;
            bot_q   <= Y_C + B1_12;
            left_q  <= X_C;
            right_q <= X_C + B1_12;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            loser_q <= loser_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            top_q   <= y_d;
            bot_q   <= y_d + B1_12;
            left_q  <= x_d;
            right_q <= x_d + B1_12;
        end
    end

    assign top_bound    = top_q;
    assign bottom_bound = bot_q;
    assign left_bound   = left_q;
    assign right_bound  = right_q;
    assign score_left   = sl_q;
    assign score_right  = sr_q;
    assign state        = state_q;
    assign hit          = hit_q;

endmodule

// File: tb/tb_ball_controller.sv
module tb_ball_controller;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        serve;
    logic [11:0] lpad_top, lpad_bottom, rpad_top, rpad_bottom;
    logic [11:0] top_bound, bottom_bound, left_bound, right_bound;
    logic [3:0]  score_left, score_right;
    logic [1:0]  state;
    logic        hit;

    ball_controller dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .serve        (serve),
        .lpad_top     (lpad_top),
        .lpad_bottom  (lpad_bottom),
        .rpad_top     (rpad_top),
        .rpad_bottom  (rpad_bottom),
        .top_bound    (top_bound),
        .bottom_bound (bottom_bound),
        .left_bound   (left_bound),
        .right_bound  (right_bound),
        .score_left   (score_left),
        .score_right  (score_right),
        .state        (state),
        .hit          (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_TOP = 0, S_BOT = 1, S_LEFT = 2, S_RIGHT = 3,
                   S_SL = 4, S_SR = 5, S_ST = 6, S_HIT = 7;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    function automatic int get(input int sel);
        case (sel)
            S_TOP:   return int'(top_bound);
            S_BOT:   return int'(bottom_bound);
            S_LEFT:  return int'(left_bound);
            S_RIGHT: return int'(right_bound);
            S_SL:    return int'(score_left);
            S_SR:    return int'(score_right);
            S_ST:    return int'(state);
            default: return int'(hit);
        endcase
    endfunction

    initial begin
        exp_t e;
        int   act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = get(e.sel);
                checks++;
                if (act != e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0d, want %0d", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input string n, input int sel, input int v);
        sb.push_back('{n, sel, v});
    endtask

    task automatic fire();
        -> chk_ev;
        #1;
    endtask

    task automatic push_center(input string n);
        push({n, ".top"},   S_TOP,   236);
        push({n, ".bot"},   S_BOT,   245);
        push({n, ".left"},  S_LEFT,  316);
        push({n, ".right"}, S_RIGHT, 325);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic serve_pulse();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0; serve = 1'b0;
        lpad_top = 12'd0; lpad_bottom = 12'd0;
        rpad_top = 12'd0; rpad_bottom = 12'd4095;

        repeat (2) @(negedge clk);
        push_center("reset");
        push("reset.state", S_ST, 0);
        push("reset.sl", S_SL, 0);
        push("reset.sr", S_SR, 0);
        push("reset.hit", S_HIT, 0);
        fire();
        checks++;
        if (state != 2'd0 || top_bound != 12'd236 || left_bound != 12'd316) begin
            errors++;
            $display("FAIL direct.reset: got state %0d top %0d left %0d, want 0/236/316",
                     state, top_bound, left_bound);
        end
        @(negedge clk) rst = 1'b0;

        serve_pulse();
        push("serve.state", S_ST, 1); fire();
        checks++;
        if (state != 2'd1) begin
            errors++;
            $display("FAIL direct.serve: got %0d, want 1", state);
        end
        ticks(3);
        push("play3.left", S_LEFT, 322); fire();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        push_center("async_rst");
        push("async_rst.state", S_ST, 0);
        fire();
        checks++;
        if (state != 2'd0 || left_bound != 12'd316) begin
            errors++;
            $display("FAIL direct.async_rst: got state %0d left %0d, want 0/316",
                     state, left_bound);
        end
        @(negedge clk) rst = 1'b0;

        serve_pulse();
        ticks(1);
        push("t1.left", S_LEFT, 318);
        push("t1.right", S_RIGHT, 327);
        push("t1.top", S_TOP, 238);
        push("t1.bot", S_BOT, 247);
        push("t1.state", S_ST, 1);
        fire();
        checks++;
        if (left_bound != 12'd318 || top_bound != 12'd238) begin
            errors++;
            $display("FAIL direct.t1: got left %0d top %0d, want 318/238",
                     left_bound, top_bound);
        end
        ticks(117);
        push("floor.top", S_TOP, 471);
        push("floor.bot", S_BOT, 480);
        push("floor.left", S_LEFT, 552);
        fire();
        ticks(30);
        push("rbounce.left", S_LEFT, 611);
        push("rbounce.right", S_RIGHT, 620);
        push("rbounce.top", S_TOP, 411);
        push("rbounce.hit", S_HIT, 1);
        fire();
        @(negedge clk);
        push("rbounce.hit_end", S_HIT, 0); fire();
        ticks(205);
        push("ceil_pre.top", S_TOP, 1); fire();
        ticks(1);
        push("ceil.top", S_TOP, 0);
        push("ceil.bot", S_BOT, 9);
        fire();
        checks++;
        if (top_bound != 12'd0) begin
            errors++;
            $display("FAIL direct.ceil: got %0d, want 0", top_bound);
        end
        ticks(1);
        push("ceil_post.top", S_TOP, 2); fire();

        ticks(99);
        push("rpoint.left", S_LEFT, 0);
        push("rpoint.right", S_RIGHT, 9);
        push("rpoint.sr", S_SR, 1);
        push("rpoint.sl", S_SL, 0);
        push("rpoint.state", S_ST, 2);
        fire();
        checks++;
        if (score_right != 4'd1 || state != 2'd2) begin
            errors++;
            $display("FAIL direct.rpoint: got sr %0d state %0d, want 1/2",
                     score_right, state);
        end
        ticks(59);
        push("hold59.state", S_ST, 2);
        push("hold59.left", S_LEFT, 0);
        fire();
        ticks(1);
        push("hold60.state", S_ST, 0);
        push_center("hold60");
        fire();
        ticks(2);
        push("serve_idle.state", S_ST, 0);
        push("serve_idle.left", S_LEFT, 316);
        fire();

        lpad_top = 12'd400; lpad_bottom = 12'd500;
        serve_pulse();
        ticks(1);
        push("lserve.left", S_LEFT, 314);
        push("lserve.top", S_TOP, 238);
        push("lserve.state", S_ST, 1);
        fire();
        ticks(146);
        push("lpre.left", S_LEFT, 22); fire();
        ticks(1);
        push("lbounce.left", S_LEFT, 20);
        push("lbounce.top", S_TOP, 411);
        push("lbounce.hit", S_HIT, 1);
        fire();
        checks++;
        if (hit != 1'b1 || left_bound != 12'd20) begin
            errors++;
            $display("FAIL direct.lbounce: got hit %0d left %0d, want 1/20",
                     hit, left_bound);
        end
        @(negedge clk);
        push("lbounce.hit_end", S_HIT, 0); fire();
        ticks(1);
        push("lpost.left", S_LEFT, 22);
        push("lpost.top", S_TOP, 409);
        fire();

        lpad_top = 12'd0; lpad_bottom = 12'd4095;
        rpad_top = 12'd0; rpad_bottom = 12'd0;
        ticks(304);
        push("lp1_pre.left", S_LEFT, 630);
        push("lp1_pre.state", S_ST, 1);
        fire();
        ticks(1);
        push("lp1.left", S_LEFT, 631);
        push("lp1.right", S_RIGHT, 640);
        push("lp1.sl", S_SL, 1);
        push("lp1.state", S_ST, 2);
        fire();
        for (int k = 2; k <= 9; k++) begin
            ticks(60);
            push($sformatf("lp%0d.reserve_state", k), S_ST, 0);
            push_center($sformatf("lp%0d.center", k));
            fire();
            serve_pulse();
            ticks(158);
            push($sformatf("lp%0d.left", k), S_LEFT, 631);
            push($sformatf("lp%0d.sl", k), S_SL, k);
            push($sformatf("lp%0d.state", k), S_ST, 2);
            fire();
        end
        ticks(59);
        push("win_hold59.state", S_ST, 2); fire();
        ticks(1);
        push("over.state", S_ST, 3);
        push("over.sl", S_SL, 9);
        push("over.sr", S_SR, 1);
        fire();
        ticks(5);
        push("over_idle.state", S_ST, 3);
        push("over_idle.sl", S_SL, 9);
        fire();
        serve_pulse();
        push("newgame.state", S_ST, 0);
        push("newgame.sl", S_SL, 0);
        push("newgame.sr", S_SR, 0);
        push_center("newgame");
        fire();
        checks++;
        if (state != 2'd0 || score_left != 4'd0 || score_right != 4'd0) begin
            errors++;
            $display("FAIL direct.newgame: got state %0d sl %0d sr %0d, want 0/0/0",
                     state, score_left, score_right);
        end

        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
